fpu_cmd_sequencer: RTL
======================

# fpu_cmd_sequencer

Sequential front-end for the combinational double-precision FPU (add/sub/mul/div on IEEE-754 64-bit operands). It buffers incoming operation requests in a small FIFO and issues one request at a time on the FPU operand bus. After a fixed settle delay it captures the FPU result together with operand-class status flags, then presents it downstream with a valid/ready handshake. The block sits directly upstream of the FPU and also owns the result register the FPU feeds.

## Interface
- DEPTH, 4 — request FIFO entries; power of two, ≥2.
- SETTLE, 1 — cycles between driving operands and sampling `fpu_result`; range 1–15.
- TAG_W, 4 — width of the user tag carried with each request.

- clk  in  1  — single clock; all state updates on its rising edge.
- rst_n  in  1  — reset; synchronous and active-low.
- in_valid  in  1  — request present.
- in_ready  out  1  — FIFO can accept; equals !full, from registered state only.
- in_a  in  64  — operand a.
- in_b  in  64  — operand b.
- in_op  in  2  — 00 add, 01 sub, 10 mul, 11 div.
- in_tag  in  TAG_W  — user tag.
- fpu_a  out  64  — operand a driven to the FPU.
- fpu_b  out  64  — operand b driven to the FPU.
- fpu_op  out  2  — op driven to the FPU.
- fpu_result  in  64  — FPU result.
- out_valid  out  1  — result register holds an unconsumed result.
- out_ready  in  1  — downstream accepts.
- out_result  out  64  — captured result.
- out_tag  out  TAG_W  — tag of the captured request.
- out_flags  out  3  — {div_by_zero, inf_operand, nan_operand}.

## Operation
- FIFO: DEPTH entries of {a, b, op, tag}. Read/write pointers have log2(DEPTH)+1 bits, and the full/empty test uses the MSB. A push happens when in_valid && in_ready. A push while full is dropped, and in_ready is already low in that state. There is no bypass: a push and a pop in the same cycle are both legal, and an entry written in cycle N is poppable in cycle N+1 at the earliest.
- FSM states:
  - IDLE: if the FIFO is not empty, pop the head into the issue register and go to ISSUE_WAIT with cnt=SETTLE-1.
  - ISSUE_WAIT: `fpu_a`/`fpu_b`/`fpu_op` are driven from the issue register and stay stable for the whole state. If cnt≠0, decrement cnt. If cnt==0, capture `fpu_result`, the tag and the flags into the output register, set out_valid, and go to HOLD.
  - HOLD: out_valid=1 and the outputs are stable. When out_ready=1, clear out_valid in the next cycle. In that same ready cycle, if the FIFO is not empty, pop the next entry and go directly to ISSUE_WAIT; otherwise go to IDLE.
- Flags are computed from the issued operands when the result is captured:
  - nan_operand = an exponent field equals 0x7FF and its fraction is non-zero, for either operand.
  - inf_operand = an exponent field equals 0x7FF and its fraction is zero, for either operand.
  - div_by_zero = op==11 and b[62:0]==0.
- Data is never modified; the block passes the FPU result through bit-exact.
- When not in ISSUE_WAIT, the operand bus holds its last issued value. It is 0 after reset.

## Timing
- Reset (rst_n=0 sampled at an edge):
  - pointers = 0 and FSM = IDLE;
  - out_valid=0, out_result=0, out_tag=0, out_flags=0;
  - fpu_a=fpu_b=0, fpu_op=0;
  - in_ready=1 from the first cycle after reset.
- Reset asserted mid-operation discards all queued and in-flight requests. No out_valid pulse follows.
- Latency from a push into an empty, idle block to out_valid=1 is SETTLE+2 cycles:
  - 1 cycle to write the FIFO;
  - 1 cycle to pop it;
  - SETTLE cycles in ISSUE_WAIT.
- Throughput with out_ready held high: one result every SETTLE+1 cycles.
- out_valid, once set, stays high until a cycle with out_ready=1. out_result, out_tag and out_flags are constant while out_valid=1 && out_ready=0.
- With out_ready held low, the FIFO fills after DEPTH further pushes and in_ready drops in the cycle after the filling push.
- Pointer wrap: after 2·DEPTH pushes and pops, the full/empty decisions must remain correct.

## Test plan
- Single add, SETTLE=1: a=0x3FF0000000000000, b=0x4000000000000000, op=00, tag=5 → out_valid 3 cycles after the push, out_result=0x4008000000000000, tag=5, flags=000.
- Back-to-back with the FPU attached and out_ready=1:
  - push mul 2.0×3.0, then div 6.0/2.0, then sub 3.0−1.0;
  - required results in order: 0x4018000000000000, 0x4008000000000000, 0x4000000000000000;
  - tags preserved; results spaced SETTLE+1 cycles apart.
- Backpressure, out_ready=0, DEPTH=4:
  - push 6 requests → in_ready low after the 5th accepted request (4 in the FIFO plus 1 in flight/held);
  - the held result stays stable;
  - releasing out_ready drains all 5 in order with no duplicates or losses.
- Flags:
  - div with b=0x0000000000000000 → flags=100;
  - add with a=0x7FF0000000000000 → 010;
  - mul with b=0x7FF8000000000000 → 001 (inf bit clear).
- Reset mid-operation: assert rst_n=0 during ISSUE_WAIT with 3 entries queued → all outputs equal their reset values next cycle, no later out_valid, and a new request after reset completes normally.
- Wrap and long run: 3·DEPTH requests with random out_ready at SETTLE=3 → every result matches the scoreboard and the operand bus stays stable throughout every ISSUE_WAIT.

Source files
------------

// File: rtl/fpu_cmd_sequencer.sv
// fpu_cmd_sequencer: queues FPU requests, issues them one at a time and holds each result for a valid/ready handshake.
module fpu_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic [63:0]      fpu_a,
  output logic [63:0]      fpu_b,
  output logic [1:0]       fpu_op,
  input  logic [63:0]      fpu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_flags
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, ISSUE_WAIT = 2'd1, HOLD = 2'd2;
  typedef struct packed {
    logic [63:0]      a;
    logic [63:0]      b;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } req_t;
  req_t mem [DEPTH];
  req_t iss;
  logic [AW:0] wptr, rptr;
  logic [1:0] state;
  logic [3:0] cnt;
  logic empty, full, push, pop;
  logic nan_a, nan_b, inf_a, inf_b;
  logic [2:0] flags;
  // Extra pointer MSB tells a full FIFO apart from an empty one when the index bits match.
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign in_ready = !full;
  assign push = in_valid && !full;
  assign pop = !empty && (state == IDLE || (state == HOLD && out_ready));
  assign nan_a = (&iss.a[62:52]) && (|iss.a[51:0]);
  assign nan_b = (&iss.b[62:52]) && (|iss.b[51:0]);
  assign inf_a = (&iss.a[62:52]) && !(|iss.a[51:0]);
  assign inf_b = (&iss.b[62:52]) && !(|iss.b[51:0]);
  assign flags = {iss.op == 2'b11 && iss.b[62:0] == 63'd0, inf_a || inf_b, nan_a || nan_b};
  assign fpu_a = iss.a;
  assign fpu_b = iss.b;
  assign fpu_op = iss.op;
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= '{in_a, in_b, in_op, in_tag};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      state <= IDLE;
      cnt <= '0;
      iss <= '0;
      out_valid <= 1'b0;
      out_result <= '0;
      out_tag <= '0;
      out_flags <= '0;
    end else begin
      if (push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop) begin
        rptr <= rptr + {{AW{1'b0}}, 1'b1};
        iss <= mem[rptr[AW-1:0]];
        cnt <= 4'(SETTLE - 1);
        state <= ISSUE_WAIT;
      end
      if (state == ISSUE_WAIT) begin
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else begin
          out_result <= fpu_result;
          out_tag <= iss.tag;
          out_flags <= flags;
          out_valid <= 1'b1;
          state <= HOLD;
        end
      end
      if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
        if (!pop) state <= IDLE;
      end
    end
  end
endmodule
